fsm_rx_burst: RTL and testbench
===============================

# fsm_rx_burst

Burst-capable read controller for the RX FIFO, replacing the single-word read FSM. A write to the `leer` control bit starts a transfer. The block then does one of two things:
- reads a programmed number of words, or
- drains the FIFO until it is empty.

Each word is presented downstream on a valid/ready handshake. When the transfer ends, the block clears the `leer` bit and reports how many words moved and whether the FIFO underflowed.

## Interface
- `DATA_W`, 8: FIFO word width.
- `CNT_W`, 8: burst-length and word-counter width. Maximum burst is 2^CNT_W−1 words.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `leer_cmd`  in  1  one-cycle pulse when the `leer` bit is written.
- `burst_len`  in  CNT_W  words to read. 0 selects drain mode. Sampled only when a command is accepted.
- `leer_bit_clear`  out  1  one-cycle pulse that clears the `leer` bit.
- `fifo_rx_empty`  in  1  FIFO empty flag.
- `fifo_rx_rd`  out  1  FIFO read strobe. Pops one word per asserted cycle.
- `fifo_rx_data`  in  DATA_W  FIFO read data, valid the cycle after `fifo_rx_rd`.
- `out_valid`  out  1  downstream word valid.
- `out_data`  out  DATA_W  downstream word.
- `out_ready`  in  1  downstream accepts the word.
- `busy`  out  1  high from command acceptance through the CLEAN state, inclusive.
- `done`  out  1  one-cycle pulse at end of transfer, coincident with `leer_bit_clear`.
- `words_read`  out  CNT_W  words handed off in the current or last transfer.
- `underflow`  out  1  sticky: a counted burst hit an empty FIFO before finishing.

## Operation
- States: IDLE, ISSUE, WAIT_DATA, PRESENT, CLEAN. Reset state is IDLE.
- IDLE:
  - `leer_cmd`=1 → ISSUE.
  - On the same edge: latch `burst_len` into `len_q`, clear `words_read` to 0, clear `underflow`.
- ISSUE:
  - Counted mode and `words_read`==`len_q` → CLEAN.
  - Otherwise, if `fifo_rx_empty`=1:
    - drain mode → CLEAN;
    - counted mode → set `underflow`, then → CLEAN.
  - Otherwise assert `fifo_rx_rd` for this cycle only (combinational from state) → WAIT_DATA.
- WAIT_DATA: capture `fifo_rx_data` into `out_data` at the edge → PRESENT. Never asserts `fifo_rx_rd`.
- PRESENT:
  - `out_valid`=1; `out_data` is held stable.
  - On `out_valid`&&`out_ready`: increment `words_read` → ISSUE.
  - Stays in PRESENT indefinitely while `out_ready`=0.
- CLEAN: `leer_bit_clear`=1 and `done`=1 for one cycle → IDLE.
- `leer_cmd` outside IDLE is ignored, with no queuing. The `leer` bit stays set until CLEAN clears it.
- Drain mode saturation: `words_read` saturates at 2^CNT_W−1. Reaching saturation ends the transfer as if the FIFO were empty.
- `underflow` and `words_read` hold after `done` until the next accepted command.
- `fifo_rx_rd` is never asserted while `fifo_rx_empty`=1.
- At most one word is in flight; there is no read-ahead.
- Undefined state encodings → IDLE.

## Timing
- Reset values (async on `rst`=0):
  - all control outputs 0: `fifo_rx_rd`, `out_valid`, `leer_bit_clear`, `done`, `busy`, `underflow`;
  - `out_data`=0, `words_read`=0;
  - state IDLE.
- Reset mid-transfer: abort immediately. No `leer_bit_clear` pulse is issued; software re-arms.
- Command at cycle 0 → ISSUE at cycle 1.
- Per word with `out_ready` held high:
  - `fifo_rx_rd` at cycle n;
  - `out_valid` at cycle n+2;
  - next `fifo_rx_rd` at cycle n+3.
  - Throughput is 1 word per 3 cycles.
- Backpressure adds one cycle per cycle `out_ready` is low.
- End of transfer: the ISSUE cycle that detects completion or empty is followed by CLEAN one cycle later; `busy` drops the cycle after CLEAN.
- Zero-word case: command accepted with FIFO empty → CLEAN at cycle 2, `words_read`=0.
- `out_ready` may be high before `out_valid`. Only the cycle where both are high counts as a transfer.

## Test plan
- Counted burst of 1: FIFO={0xA5}, `burst_len`=1, `out_ready`=1.
  - Required: one `fifo_rx_rd`, `out_data`=0xA5 valid 2 cycles later, then `done`/`leer_bit_clear` together;
  - `words_read`=1, `underflow`=0, FIFO empty.
- Counted burst with backpressure: FIFO={0x11,0x22,0x33,0x44,0x55}, `burst_len`=4, `out_ready` low for 3 cycles on word 2.
  - Required: 0x11..0x44 in order, `out_data` stable while stalled, exactly 4 reads;
  - 0x55 remains in FIFO, `words_read`=4.
- Drain mode: FIFO={0x01,0x02,0x03}, `burst_len`=0.
  - Required: 3 words delivered, `words_read`=3, `underflow`=0, no read issued while empty.
- Underflow: FIFO={0xAA,0xBB}, `burst_len`=5.
  - Required: 2 words delivered, then CLEAN; `underflow`=1, `words_read`=2.
  - Required: a following command clears `underflow` on acceptance.
- Command while busy: second `leer_cmd` pulsed mid-burst.
  - Required: ignored, a single `done` pulse, no extra reads.
- Reset mid-PRESENT: `rst`=0 while `out_valid`=1.
  - Required: all outputs 0 at once, no `leer_bit_clear` pulse;
  - normal operation after release.

Source files
------------

// File: rtl/fsm_rx_burst_if.sv
// Handshake bundle for the burst RX reader: FIFO pop side plus downstream valid/ready stream.
interface fsm_rx_burst_if #(
  parameter int DATA_W = 8
);
  logic              fifo_rx_empty;
  logic              fifo_rx_rd;
  logic [DATA_W-1:0] fifo_rx_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    input  fifo_rx_empty,
    input  fifo_rx_data,
    input  out_ready,
    output fifo_rx_rd,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_rx_empty,
    output fifo_rx_data,
    output out_ready,
    input  fifo_rx_rd,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fsm_rx_burst.sv
// Burst read controller for the RX FIFO: counted or drain-until-empty transfers, one word in flight,
// each word handed downstream on valid/ready, ending with a leer-clear/done pulse.
module fsm_rx_burst #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             leer_cmd,
  input  logic [CNT_W-1:0] burst_len,
  output logic             leer_bit_clear,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_read,
  output logic             underflow,
  fsm_rx_burst_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DATA = 3'd2,
    PRESENT   = 3'd3,
    CLEAN     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] WORDS_MAX = '1;

  state_t            state;
  logic [CNT_W-1:0]  len_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              drain_mode;
  logic              count_done;
  logic              drain_sat;
  logic              finish_now;

  // Saturation in drain mode ends the transfer exactly like an empty FIFO would.
  assign drain_mode = (len_q == '0);
  assign count_done = !drain_mode && (words_read == len_q);
  assign drain_sat  = drain_mode && (words_read == WORDS_MAX);
  assign finish_now = count_done || drain_sat;

  assign bus.fifo_rx_rd = (state == ISSUE) && !finish_now && !bus.fifo_rx_empty;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      len_q          <= '0;
      words_read     <= '0;
      underflow      <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      leer_bit_clear <= 1'b0;
    end else begin
      done           <= 1'b0;
      leer_bit_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (leer_cmd) begin
            state      <= ISSUE;
            len_q      <= burst_len;
            words_read <= '0;
            underflow  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if (finish_now) begin
            state          <= CLEAN;
            done           <= 1'b1;
            leer_bit_clear <= 1'b1;
          end else if (bus.fifo_rx_empty) begin
            if (!drain_mode) begin
              underflow <= 1'b1;
            end
            state          <= CLEAN;
            done           <= 1'b1;
            leer_bit_clear <= 1'b1;
          end else begin
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          out_data_q  <= bus.fifo_rx_data;
          out_valid_q <= 1'b1;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            words_read  <= words_read + 1'b1;
            state       <= ISSUE;
          end
        end
        CLEAN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy        <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_rx_burst.sv
// Directed bench for fsm_rx_burst: a small FIFO model feeds the DUT and each scenario task
// checks timing, data order and status against hand-computed expectations.
module tb_fsm_rx_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       leer_cmd = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       leer_bit_clear;
  logic       busy;
  logic       done;
  logic [7:0] words_read;
  logic       underflow;

  fsm_rx_burst_if #(.DATA_W(8)) bif ();

  fsm_rx_burst #(.DATA_W(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .leer_cmd      (leer_cmd),
    .burst_len     (burst_len),
    .leer_bit_clear(leer_bit_clear),
    .busy          (busy),
    .done          (done),
    .words_read    (words_read),
    .underflow     (underflow),
    .bus           (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic flush = 1'b0;
  logic fifo_empty;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign bif.fifo_rx_empty = fifo_empty;

  int rd_count = 0;
  int rd_while_empty = 0;
  int done_count = 0;
  int lbc_count = 0;
  logic [7:0] got [0:63];
  int got_n = 0;

  // FIFO model plus passive counters; data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (rst) begin
      if (bif.fifo_rx_rd) begin
        rd_count <= rd_count + 1;
        if (fifo_empty) rd_while_empty <= rd_while_empty + 1;
      end
      if (done) done_count <= done_count + 1;
      if (leer_bit_clear) lbc_count <= lbc_count + 1;
      if (bif.out_valid && bif.out_ready) begin
        got[got_n % 64] <= bif.out_data;
        got_n <= got_n + 1;
      end
    end
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bif.fifo_rx_rd && !fifo_empty) begin
      bif.fifo_rx_data <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic start_cmd(input logic [7:0] len);
    @(negedge clk);
    burst_len = len;
    leer_cmd = 1'b1;
  endtask

  // Cycle index of the done pulse counted from the command cycle, or -1 when the budget runs out.
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      leer_cmd = 1'b0;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bif.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bif.fifo_rx_rd, bif.out_valid, leer_bit_clear, done, busy, underflow} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {bif.fifo_rx_rd, bif.out_valid, leer_bit_clear, done, busy, underflow});
    end
    checks++;
    if (bif.out_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_out_data: got %h expected 00", bif.out_data);
    end
    checks++;
    if (words_read !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_words_read: got %0d expected 0", words_read);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_burst_one();
    int rd0;
    rd0 = rd_count;
    push(8'hA5);
    bif.out_ready = 1'b1;
    start_cmd(8'd1);
    @(negedge clk);
    leer_cmd = 1'b0;
    checks++;
    if ({bif.fifo_rx_rd, busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL one_issue rd,busy: got %b expected 11", {bif.fifo_rx_rd, busy});
    end
    @(negedge clk);
    checks++;
    if ({bif.fifo_rx_rd, bif.out_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL one_wait rd,valid: got %b expected 00", {bif.fifo_rx_rd, bif.out_valid});
    end
    @(negedge clk);
    checks++;
    if ({bif.out_valid, bif.out_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("[TB] FAIL one_present valid,data: got %b,%h expected 1,a5", bif.out_valid, bif.out_data);
    end
    @(negedge clk);
    checks++;
    if ({done, leer_bit_clear, bif.fifo_rx_rd} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL one_final_issue done,clr,rd: got %b expected 000", {done, leer_bit_clear, bif.fifo_rx_rd});
    end
    @(negedge clk);
    checks++;
    if ({done, leer_bit_clear, busy} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL one_clean done,clr,busy: got %b expected 111", {done, leer_bit_clear, busy});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, words_read, underflow} !== {1'b0, 1'b0, 8'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL one_after done,busy,words,uf: got %b,%b,%0d,%b expected 0,0,1,0",
               done, busy, words_read, underflow);
    end
    checks++;
    if ((rd_count - rd0) !== 1 || fifo_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL one_reads: got %0d reads empty=%b expected 1 reads empty=1", rd_count - rd0, fifo_empty);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_w [4];
    logic [7:0] held;
    int rd0, gb, stall, cyc;
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd0 = rd_count;
    gb = got_n;
    stall = 0;
    cyc = -1;
    held = 8'h00;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    bif.out_ready = 1'b1;
    start_cmd(8'd4);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      leer_cmd = 1'b0;
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
      if (bif.out_valid === 1'b1 && (got_n - gb) == 1 && stall < 3) begin
        if (stall == 0) begin
          held = bif.out_data;
        end else begin
          checks++;
          if (bif.out_data !== held) begin
            errors++;
            $display("[TB] FAIL bp_stable: got %h expected %h", bif.out_data, held);
          end
        end
        bif.out_ready = 1'b0;
        stall++;
      end else begin
        bif.out_ready = 1'b1;
      end
    end
    bif.out_ready = 1'b1;
    checks++;
    if (cyc !== 17) begin
      errors++;
      $display("[TB] FAIL bp_done_cycle: got %0d expected 17", cyc);
    end
    checks++;
    if (held !== 8'h22) begin
      errors++;
      $display("[TB] FAIL bp_stalled_word: got %h expected 22", held);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[(gb + k) % 64] !== exp_w[k]) begin
        errors++;
        $display("[TB] FAIL bp_word%0d: got %h expected %h", k, got[(gb + k) % 64], exp_w[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ((rd_count - rd0) !== 4 || (wr_ptr - rd_ptr) !== 1 || words_read !== 8'd4) begin
      errors++;
      $display("[TB] FAIL bp_counts: got reads=%0d left=%0d words=%0d expected 4,1,4",
               rd_count - rd0, wr_ptr - rd_ptr, words_read);
    end
    do_flush();
  endtask

  task automatic test_drain();
    int rd0, gb, we0, cyc;
    rd0 = rd_count;
    gb = got_n;
    we0 = rd_while_empty;
    push(8'h01); push(8'h02); push(8'h03);
    start_cmd(8'd0);
    wait_done(50, cyc);
    checks++;
    if (cyc !== 11) begin
      errors++;
      $display("[TB] FAIL drain_done_cycle: got %0d expected 11", cyc);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[(gb + k) % 64] !== 8'(k + 1)) begin
        errors++;
        $display("[TB] FAIL drain_word%0d: got %h expected %h", k, got[(gb + k) % 64], 8'(k + 1));
      end
    end
    checks++;
    if ({words_read, underflow} !== {8'd3, 1'b0} || (rd_count - rd0) !== 3 || (rd_while_empty - we0) !== 0) begin
      errors++;
      $display("[TB] FAIL drain_status: got words=%0d uf=%b reads=%0d empty_reads=%0d expected 3,0,3,0",
               words_read, underflow, rd_count - rd0, rd_while_empty - we0);
    end
  endtask

  task automatic test_underflow();
    int gb, cyc;
    gb = got_n;
    push(8'hAA); push(8'hBB);
    start_cmd(8'd5);
    wait_done(50, cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("[TB] FAIL uf_done_cycle: got %0d expected 8", cyc);
    end
    @(negedge clk);
    checks++;
    if ({underflow, words_read} !== {1'b1, 8'd2} || got_n - gb !== 2) begin
      errors++;
      $display("[TB] FAIL uf_status: got uf=%b words=%0d delivered=%0d expected 1,2,2",
               underflow, words_read, got_n - gb);
    end
    checks++;
    if (got[gb % 64] !== 8'hAA || got[(gb + 1) % 64] !== 8'hBB) begin
      errors++;
      $display("[TB] FAIL uf_words: got %h %h expected aa bb", got[gb % 64], got[(gb + 1) % 64]);
    end
    push(8'h77);
    start_cmd(8'd1);
    @(negedge clk);
    leer_cmd = 1'b0;
    checks++;
    if ({underflow, words_read, busy} !== {1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL uf_clear_on_accept: got uf=%b words=%0d busy=%b expected 0,0,1",
               underflow, words_read, busy);
    end
    wait_done(30, cyc);
    @(negedge clk);
    checks++;
    if ({underflow, words_read} !== {1'b0, 8'd1}) begin
      errors++;
      $display("[TB] FAIL uf_next_status: got uf=%b words=%0d (done at %0d) expected 0,1", underflow, words_read, cyc);
    end
  endtask

  task automatic test_cmd_while_busy();
    int rd0, dc0, first;
    rd0 = rd_count;
    dc0 = done_count;
    first = -1;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    start_cmd(8'd3);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      leer_cmd = (i == 4);
      if (i == 4) burst_len = 8'd1;
      if (done === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first !== 11) begin
      errors++;
      $display("[TB] FAIL busy_done_cycle: got %0d expected 11", first);
    end
    checks++;
    if ((done_count - dc0) !== 1 || (rd_count - rd0) !== 3 || words_read !== 8'd3) begin
      errors++;
      $display("[TB] FAIL busy_ignore: got dones=%0d reads=%0d words=%0d expected 1,3,3",
               done_count - dc0, rd_count - rd0, words_read);
    end
    do_flush();
  endtask

  task automatic test_reset_mid_present();
    int lc0, cyc, seen;
    lc0 = lbc_count;
    seen = 0;
    push(8'hC1); push(8'hC2);
    bif.out_ready = 1'b0;
    start_cmd(8'd2);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      leer_cmd = 1'b0;
      if (bif.out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen !== 1) begin
      errors++;
      $display("[TB] FAIL rstmid_reach_present: got %0d expected 1", seen);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bif.fifo_rx_rd, bif.out_valid, leer_bit_clear, done, busy, underflow, bif.out_data, words_read} !== 22'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: got valid=%b busy=%b clr=%b data=%h words=%0d expected all 0",
               bif.out_valid, busy, leer_bit_clear, bif.out_data, words_read);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bif.out_ready = 1'b1;
    do_flush();
    repeat (2) @(negedge clk);
    checks++;
    if ((lbc_count - lc0) !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_no_clear: got clears=%0d busy=%b expected 0,0", lbc_count - lc0, busy);
    end
    push(8'h5A);
    start_cmd(8'd1);
    wait_done(30, cyc);
    @(negedge clk);
    checks++;
    if (cyc !== 5 || words_read !== 8'd1 || got[(got_n - 1) % 64] !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL rstmid_recover: got done_cycle=%0d words=%0d last=%h expected 5,1,5a",
               cyc, words_read, got[(got_n - 1) % 64]);
    end
  endtask

  initial begin
    bif.out_ready = 1'b0;
    test_reset();
    test_burst_one();
    test_backpressure();
    test_drain();
    test_underflow();
    test_cmd_while_busy();
    test_reset_mid_present();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
